// File: rtl/ftq_fetch_issue.sv
// ftq_fetch_issue
// Sits directly behind the fetch target queue. Each FTQ head entry describes
// a fetch block (word-aligned start PC plus instruction count minus one). The
// block is turned into one I-cache line request, or two when it crosses a
// 32-byte line. A credit counter bounds the number of outstanding I-cache
// requests, and a stale counter marks responses to requests issued before a
// backend flush so they can be discarded.
//
// Ports:
//   Clk, Rest      clock and synchronous active-high reset
//   FtqHead        FTQ head entry {BlkPc[PC_W-1:2], BlkLen[2:0]}
//   FtqEmpty       FTQ has no valid entry
//   FtqRable       FTQ pop strobe (entry captured this cycle)
//   Flush          backend redirect; discards the held block
//   FtqClean       FTQ clear strobe, mirrors Flush
//   IcReqValid     I-cache request valid
//   IcReqReady     I-cache accepts the request
//   IcReqAddr      request start byte address, word aligned
//   IcReqNum       instructions in this request minus one
//   IcReqLast      final piece of the current fetch block
//   IcRespValid    one in-order I-cache response
//   IcRespDrop     current response belongs to a pre-flush request
module ftq_fetch_issue #(
    parameter int PC_W      = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic [PC_W:0]   FtqHead,
    input  logic            FtqEmpty,
    output logic            FtqRable,
    input  logic            Flush,
    output logic            FtqClean,
    output logic            IcReqValid,
    input  logic            IcReqReady,
    output logic [PC_W-1:0] IcReqAddr,
    output logic [2:0]      IcReqNum,
    output logic            IcReqLast,
    input  logic            IcRespValid,
    output logic            IcRespDrop
);

    typedef enum logic [1:0] {IDLE, P0, P1} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    state_t          state;
    state_t          state_next;
    logic [PC_W-3:0] blk_pc;
    logic [2:0]      blk_len;
    logic [3:0]      out_cnt;
    logic [3:0]      stale_cnt;

    logic            acc;
    logic            load_ok;
    logic            credit_ok;
    logic [3:0]      span;
    logic            split;
    logic [PC_W-6:0] next_line;

    // span = offset of the first word in its line plus (count - 1); a value
    // of 8 or more means the block runs past the end of the 32-byte line.
    assign span      = {1'b0, blk_pc[2:0]} + {1'b0, blk_len};
    assign split     = span[3];
    assign next_line = blk_pc[PC_W-3:3] + 1'b1;
    assign credit_ok = out_cnt < MAX_CNT;
    assign acc       = IcReqValid && IcReqReady;

    // A new block is taken either into an empty stage or in the same cycle
    // the final piece of the current block is accepted, so consecutive
    // blocks issue without a bubble. Reset suppresses the pop so no FTQ
    // entry is lost while the stage is being cleared.
    assign load_ok = !FtqEmpty && !Flush && !Rest &&
                     ((state == IDLE) || (acc && IcReqLast));

    // State register
    always_ff @(posedge Clk) begin
        if (Rest) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush dominates everything
    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load_ok) state_next = P0;
                end
                P0: begin
                    if (acc) begin
                        if (!IcReqLast)   state_next = P1;
                        else if (load_ok) state_next = P0;
                        else              state_next = IDLE;
                    end
                end
                P1: begin
                    if (acc) state_next = load_ok ? P0 : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic; request fields are forced to zero while idle
    always_comb begin
        IcReqValid = 1'b0;
        IcReqAddr  = '0;
        IcReqNum   = 3'd0;
        IcReqLast  = 1'b0;
        FtqRable   = load_ok;
        FtqClean   = Flush;
        IcRespDrop = IcRespValid && (stale_cnt != 4'd0);
        case (state)
            P0: begin
                IcReqValid = credit_ok && !Flush;
                IcReqAddr  = {blk_pc, 2'b00};
                IcReqNum   = split ? (3'd7 - blk_pc[2:0]) : blk_len;
                IcReqLast  = !split;
            end
            P1: begin
                IcReqValid = credit_ok && !Flush;
                IcReqAddr  = {next_line, 5'b00000};
                IcReqNum   = span[2:0];
                IcReqLast  = 1'b1;
            end
            default: ;
        endcase
    end

    // Entry capture, credit tracking and stale-response accounting. On a
    // flush every request still outstanding after this cycle's response
    // becomes stale; in-order return means those arrive before any new one.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            blk_pc    <= '0;
            blk_len   <= 3'd0;
            out_cnt   <= 4'd0;
            stale_cnt <= 4'd0;
        end else begin
            if (load_ok) begin
                blk_pc  <= FtqHead[PC_W:3];
                blk_len <= FtqHead[2:0];
            end
            out_cnt <= out_cnt + {3'b000, acc} - {3'b000, IcRespValid};
            if (Flush) begin
                stale_cnt <= out_cnt - {3'b000, IcRespValid};
            end else if (IcRespDrop) begin
                stale_cnt <= stale_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ftq_fetch_issue.sv
// Self-checking bench for ftq_fetch_issue: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based model of the fetch-block splitting rules.
module tb_ftq_fetch_issue;

    localparam int PC_W      = 32;
    localparam int MAX_OUTST = 4;

    logic          Clk = 1'b0;
    logic          Rest;
    logic [PC_W:0] FtqHead;
    logic          FtqEmpty;
    logic          FtqRable;
    logic          Flush;
    logic          FtqClean;
    logic          IcReqValid;
    logic          IcReqReady;
    logic [31:0]   IcReqAddr;
    logic [2:0]    IcReqNum;
    logic          IcReqLast;
    logic          IcRespValid;
    logic          IcRespDrop;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  num;
        logic        last;
    } piece_t;

    piece_t      pieces[$];
    logic [32:0] ftq[$];
    int          outst;
    int          stale;
    int          checks;
    int          passes;

    always #5 Clk = ~Clk;

    ftq_fetch_issue #(.PC_W(PC_W), .MAX_OUTST(MAX_OUTST)) dut (
        .Clk(Clk), .Rest(Rest), .FtqHead(FtqHead), .FtqEmpty(FtqEmpty),
        .FtqRable(FtqRable), .Flush(Flush), .FtqClean(FtqClean),
        .IcReqValid(IcReqValid), .IcReqReady(IcReqReady),
        .IcReqAddr(IcReqAddr), .IcReqNum(IcReqNum), .IcReqLast(IcReqLast),
        .IcRespValid(IcRespValid), .IcRespDrop(IcRespDrop)
    );

    function automatic logic [32:0] mkEntry(logic [31:0] pc, logic [2:0] len);
        return {pc[31:2], len};
    endfunction

    // Expand one fetch block into its line requests
    task automatic loadPieces(input logic [32:0] e);
        logic [31:0] pc;
        logic [31:0] nxt;
        int          o;
        int          l;
        piece_t      p;
        pc  = {e[32:3], 2'b00};
        o   = int'((pc >> 2) & 32'd7);
        l   = int'(e[2:0]);
        nxt = ((pc >> 5) + 32'd1) << 5;
        if (o + l <= 7) begin
            p.addr = pc; p.num = 3'(l); p.last = 1'b1;
            pieces.push_back(p);
        end else begin
            p.addr = pc; p.num = 3'(7 - o); p.last = 1'b0;
            pieces.push_back(p);
            p.addr = nxt; p.num = 3'(o + l - 8); p.last = 1'b1;
            pieces.push_back(p);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input bit fl, input bit rdy, input bit rsp,
                                 input bit hold);
        Rest        = 1'b0;
        Flush       = fl;
        IcReqReady  = rdy;
        IcRespValid = rsp;
        FtqEmpty    = (ftq.size() == 0) || hold;
        FtqHead     = (ftq.size() != 0) ? ftq[0] : '0;
    endtask

    // One clock: drive at the falling edge, compare just after, then advance
    // the model to what the next rising edge must produce.
    task automatic runCycle(input bit fl, input bit rdy, input bit rsp,
                            input bit hold);
        bit exp_valid, exp_acc, exp_rable, exp_drop, rsp_eff;
        @(negedge Clk);
        rsp_eff = rsp && (outst > 0);
        applyStimulus(fl, rdy, rsp_eff, hold);
        #1;
        exp_valid = (pieces.size() != 0) && (outst < MAX_OUTST) && !fl;
        exp_acc   = exp_valid && rdy;
        exp_rable = !FtqEmpty && !fl &&
                    ((pieces.size() == 0) || (exp_acc && pieces.size() == 1));
        exp_drop  = rsp_eff && (stale > 0);
        checkOutput("valid", 64'(IcReqValid), 64'(exp_valid));
        checkOutput("rable", 64'(FtqRable), 64'(exp_rable));
        checkOutput("clean", 64'(FtqClean), 64'(fl));
        checkOutput("drop", 64'(IcRespDrop), 64'(exp_drop));
        if (exp_valid) begin
            checkOutput("addr", 64'(IcReqAddr), 64'(pieces[0].addr));
            checkOutput("num", 64'(IcReqNum), 64'(pieces[0].num));
            checkOutput("last", 64'(IcReqLast), 64'(pieces[0].last));
        end
        if (fl) begin
            stale = outst - int'(rsp_eff);
            outst = outst - int'(rsp_eff);
            pieces.delete();
        end else begin
            if (exp_drop) stale--;
            outst = outst + int'(exp_acc) - int'(rsp_eff);
            if (exp_acc) void'(pieces.pop_front());
            if (exp_rable) loadPieces(ftq.pop_front());
        end
    endtask

    task automatic doReset();
        @(negedge Clk);
        Rest        = 1'b1;
        Flush       = 1'b0;
        IcReqReady  = 1'b0;
        IcRespValid = 1'b0;
        FtqEmpty    = 1'b1;
        FtqHead     = '0;
        pieces.delete();
        outst = 0;
        stale = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 64'(IcReqValid), 64'd0);
        checkOutput({tag, "_rable"}, 64'(FtqRable), 64'd0);
        checkOutput({tag, "_clean"}, 64'(FtqClean), 64'd0);
        checkOutput({tag, "_drop"}, 64'(IcRespDrop), 64'd0);
        checkOutput({tag, "_addr"}, 64'(IcReqAddr), 64'd0);
        checkOutput({tag, "_num"}, 64'(IcReqNum), 64'd0);
        checkOutput({tag, "_last"}, 64'(IcReqLast), 64'd0);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ftq.size() == 0 && pieces.size() == 0 && outst == 0) begin
                done = 1'b1;
                break;
            end
            runCycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        checkOutput("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        int acc_cnt;
        int rables;
        checks = 0;
        passes = 0;
        outst  = 0;
        stale  = 0;
        doReset();
        doReset();

        // Reset state
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkAllZero("reset");

        // Single block
        ftq.push_back(mkEntry(32'h1C000000, 3'd3));
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("single_rable", 64'(FtqRable), 64'd1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("single_valid", 64'(IcReqValid), 64'd1);
        checkOutput("single_addr", 64'(IcReqAddr), 64'h1C000000);
        checkOutput("single_num", 64'(IcReqNum), 64'd3);
        checkOutput("single_last", 64'(IcReqLast), 64'd1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("single_idle", 64'(IcReqValid), 64'd0);
        drain();

        // Split block
        ftq.push_back(mkEntry(32'h1C000014, 3'd5));
        rables = 0;
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        rables += int'(FtqRable);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        rables += int'(FtqRable);
        checkOutput("split0_addr", 64'(IcReqAddr), 64'h1C000014);
        checkOutput("split0_num", 64'(IcReqNum), 64'd2);
        checkOutput("split0_last", 64'(IcReqLast), 64'd0);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        rables += int'(FtqRable);
        checkOutput("split1_addr", 64'(IcReqAddr), 64'h1C000020);
        checkOutput("split1_num", 64'(IcReqNum), 64'd2);
        checkOutput("split1_last", 64'(IcReqLast), 64'd1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        rables += int'(FtqRable);
        checkOutput("split_pops", 64'(rables), 64'd1);
        drain();

        // Backpressure then back-to-back
        ftq.push_back(mkEntry(32'h00001000, 3'd1));
        ftq.push_back(mkEntry(32'h00002000, 3'd0));
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            runCycle(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("hold_valid", 64'(IcReqValid), 64'd1);
            checkOutput("hold_addr", 64'(IcReqAddr), 64'h1000);
            checkOutput("hold_num", 64'(IcReqNum), 64'd1);
            checkOutput("hold_last", 64'(IcReqLast), 64'd1);
        end
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_rable", 64'(FtqRable), 64'd1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_valid", 64'(IcReqValid), 64'd1);
        checkOutput("b2b_addr", 64'(IcReqAddr), 64'h2000);
        drain();

        // Credit limit
        for (int i = 1; i <= 6; i++) ftq.push_back(mkEntry(32'(i * 256), 3'd0));
        acc_cnt = 0;
        repeat (7) begin
            runCycle(1'b0, 1'b1, 1'b0, 1'b0);
            if (IcReqValid && IcReqReady) acc_cnt++;
        end
        checkOutput("credit_accepts", 64'(acc_cnt), 64'd4);
        checkOutput("credit_block", 64'(IcReqValid), 64'd0);
        runCycle(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("credit_resp_cycle", 64'(IcReqValid), 64'd0);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("credit_fifth_valid", 64'(IcReqValid), 64'd1);
        checkOutput("credit_fifth_addr", 64'(IcReqAddr), 64'h500);
        drain();

        // Flush with 3 outstanding while P1 is pending
        ftq.push_back(mkEntry(32'h00000300, 3'd0));
        ftq.push_back(mkEntry(32'h00000400, 3'd0));
        ftq.push_back(mkEntry(32'h00000514, 3'd5));
        repeat (4) runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        runCycle(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_clean", 64'(FtqClean), 64'd1);
        checkOutput("flush_valid", 64'(IcReqValid), 64'd0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_idle", 64'(IcReqValid), 64'd0);
        ftq.push_back(mkEntry(32'h00000700, 3'd0));
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("postflush_rable", 64'(FtqRable), 64'd1);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("postflush_valid", 64'(IcReqValid), 64'd1);
        checkOutput("postflush_addr", 64'(IcReqAddr), 64'h700);
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("stale_drop", 64'(IcRespDrop), (i < 3) ? 64'd1 : 64'd0);
        end
        drain();

        // Reset in the middle of a split block
        ftq.push_back(mkEntry(32'h00000614, 3'd5));
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        runCycle(1'b0, 1'b1, 1'b0, 1'b0);
        doReset();
        runCycle(1'b0, 1'b0, 1'b1, 1'b0);
        checkAllZero("midreset");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (ftq.size() < 3 && ($urandom % 3) == 0) begin
                logic [31:0] pc;
                pc = $urandom;
                if (($urandom % 8) == 0) pc = 32'hFFFFFFE0 | (pc & 32'h1F);
                ftq.push_back(mkEntry(pc, 3'($urandom)));
            end
            if (($urandom % 700) == 0) doReset();
            runCycle(1'(($urandom % 25) == 0), 1'(($urandom % 10) < 7),
                     1'($urandom % 2), 1'(($urandom % 8) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ftq_fetch_issue.md
Name: ftq_fetch_issue

Overview:
- Stage directly downstream of the fetch target queue FIFO (show-ahead head, pop on read-enable).
- Takes one fetch-block entry per load from the FTQ head and turns it into one or two I-cache line requests, splitting any block that crosses a 32-byte line.
- Limits outstanding I-cache requests with a credit counter.
- Handles backend flush, including marking responses to pre-flush requests as stale.

Parameters:
- PC_W, 32: PC width. The FTQ entry width is PC_W+1.
- MAX_OUTST, 4: maximum accepted-but-unanswered I-cache requests (1..15).

Ports:
- Clk  in  1  clock
- Rest  in  1  synchronous reset, active-high
- FtqHead  in  PC_W+1  FTQ head entry = {BlkPc[PC_W-1:2], BlkLen[2:0]}. BlkLen = instruction count minus 1.
- FtqEmpty  in  1  FTQ has no valid entry
- FtqRable  out  1  FTQ pop strobe
- Flush  in  1  backend redirect/flush
- FtqClean  out  1  FTQ clear strobe
- IcReqValid  out  1  I-cache request valid
- IcReqReady  in  1  I-cache accepts request
- IcReqAddr  out  PC_W  request start byte address, word aligned
- IcReqNum  out  3  instructions in this request minus 1
- IcReqLast  out  1  final piece of the current fetch block
- IcRespValid  in  1  one I-cache response returned, in order
- IcRespDrop  out  1  current response is stale and must be discarded

Behaviour:
- Reset (Rest=1 at a clock edge):
  - State goes to IDLE.
  - OutCnt and StaleCnt go to 0.
  - Entry registers go to 0.
  - All outputs are 0 from the following cycle.
  - Reset mid-block abandons the block. No responses are expected after reset.
- States:
  - IDLE: no block held.
  - P0: first or only piece pending.
  - P1: second piece of a split block pending.
- Load condition: LoadOk = !FtqEmpty && !Flush && (state==IDLE || (Acc && IcReqLast)), where Acc = IcReqValid && IcReqReady.
- On load:
  - FtqRable=1 for that cycle (combinational).
  - FtqHead is captured into entry registers and state goes to P0.
  - Pop happens at capture, so back-to-back blocks issue with no bubble.
- Split computation, with off = BlkPc[4:2] and len = BlkLen:
  - Single piece (off+len <= 7): P0 sends Addr={BlkPc,2'b00}, Num=len, Last=1.
  - Split (off+len > 7):
    - P0 sends Addr={BlkPc,2'b00}, Num=7-off, Last=0.
    - P1 sends Addr={BlkPc[PC_W-1:5]+1, 5'b0}, Num=off+len-8, Last=1.
  - The line index increment wraps modulo 2^(PC_W-5).
- Transitions:
  - P0 with Acc && !Last goes to P1.
  - Acc && Last goes to P0 if LoadOk, else IDLE.
  - Without Acc, state holds.
- IcReqValid = (state!=IDLE) && (OutCnt < MAX_OUTST) && !Flush, combinational from registers plus Flush.
- Request hold: while IcReqValid && !IcReqReady, Addr/Num/Last stay stable and Valid stays high. This holds because OutCnt cannot rise without Acc; Flush is the only exception.
- OutCnt:
  - Next = OutCnt + Acc - IcRespValid.
  - Never underflows (responses only follow accepted requests).
  - Simultaneous accept and response leaves it unchanged.
- Flush (highest priority):
  - FtqClean = Flush, combinational.
  - FtqRable is forced 0 and no load occurs.
  - State goes to IDLE next cycle, discarding any held block or pending P1.
  - StaleCnt <= OutCnt - IcRespValid, i.e. all currently outstanding requests become stale. No acceptance is possible in a flush cycle.
  - Flush while already IDLE has the same effect.
- IcRespDrop = IcRespValid && (StaleCnt != 0). StaleCnt decrements on each dropped response.
- Flush arriving while StaleCnt>0: StaleCnt <= OutCnt - IcRespValid, which still covers all older requests.
- Normal issue after flush needs no wait for StaleCnt to drain. Responses are in order, so stale ones arrive first.

Test Plan:
- Single block, ready=1:
  - Stimulus: FtqHead={0x1C000000>>2, 3'd3}, FtqEmpty=0.
  - Required: FtqRable=1 in cycle 0. Cycle 1: IcReqValid=1, Addr=0x1C000000, Num=3, Last=1.
  - Required: empty=1 afterwards leads to IDLE.
- Split block:
  - Stimulus: BlkPc=0x1C000014 (off 5), BlkLen=5.
  - Required: piece 0 Addr=0x1C000014, Num=2, Last=0. Piece 1 Addr=0x1C000020, Num=2, Last=1.
  - Required: exactly one FtqRable pulse.
- Backpressure and back-to-back:
  - Stimulus: IcReqReady=0 for 3 cycles.
  - Required: Valid/Addr/Num/Last held constant for 3 cycles.
  - Stimulus: then ready=1 with the next entry at head.
  - Required: next block's P0 appears the very next cycle, with FtqRable=1 in the accept cycle.
- Credit limit:
  - Stimulus: MAX_OUTST=4, 6 single-piece entries, ready=1, no responses.
  - Required: exactly 4 accepts, then IcReqValid=0.
  - Stimulus: one IcRespValid.
  - Required: the 5th request issues the next cycle.
- Flush with 3 outstanding, while P1 is pending:
  - Required: FtqClean=1 and IcReqValid=0 in the flush cycle; IDLE next cycle.
  - Required: the next 3 responses have IcRespDrop=1 and the 4th has IcRespDrop=0.
  - Required: a new entry after flush issues without waiting.
- Reset mid-split:
  - Stimulus: Rest=1 while in P1.
  - Required: all outputs 0 next cycle, OutCnt=0, StaleCnt=0, state IDLE.
